ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipelined CPU. It sits directly downstream of the ID/EX pipeline register and consumes its control bits, operands, immediate and register addresses. It resolves RAW hazards by forwarding, decodes ALU control, computes the result, and registers everything into the EX/MEM pipeline register that feeds the data-memory stage. With the optional sequential multiplier, it stalls the front of the pipeline until the product is ready.

## Interface
- No parameters; data width fixed at 32, register address width at 5.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegDst_i  in  1 each  control from ID/EX.
- ALUOp_i  in  2  00 add, 01 sub, 10 R-type (by funct), 11 or.
- RSdata_i, RTdata_i, Sign_extend_i  in  32  operands and immediate from ID/EX; funct = Sign_extend_i[5:0].
- RSaddr_i, RTaddr_i, RDaddr_i  in  5  register addresses from ID/EX.
- WB_RegWrite_i  in  1, WB_RDaddr_i  in  5, WB_data_i  in  32  MEM/WB writeback, used for forwarding.
- RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o  out  1 each  EX/MEM registered control.
- ALUresult_o  out  32  registered ALU result or memory address.
- MemWdata_o  out  32  registered forwarded RT value, used as store data.
- RDaddr_o  out  5  registered destination register.
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle.

## Operation
- Forwarding applies to RS and RT independently:
  - Use EX/MEM (ALUresult_o) if RegWrite_o, RDaddr_o != 0 and RDaddr_o == addr.
  - Else use WB (WB_data_i) if WB_RegWrite_i, WB_RDaddr_i != 0 and WB_RDaddr_i == addr.
  - Else use the ID/EX data.
  - EX/MEM has priority over WB.
- ALU operand A = forwarded RS. Operand B = ALUSrc_i ? Sign_extend_i : forwarded RT.
- ALUOp 10 funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - 0x2A slt: signed; result 1 or 0.
  - 0x18 mul: see Configuration.
  - Any other funct: result 0.
- Arithmetic is 32-bit modulo; overflow is ignored with no trap.
- Destination = RegDst_i ? RDaddr_i : RTaddr_i.
- Load-use hazards are detected upstream. This block forwards ALUresult_o for a load, which is the address, never the loaded data.
- Multiplier FSM states: IDLE, BUSY, DONE. Without MUL_EN the FSM is permanently IDLE.
  - IDLE: on a mul, latch the forwarded operands, clear the accumulator, count := 0, go to BUSY. stall_o = 1 in this cycle.
  - BUSY: one shift-add step per cycle; count increments. After the step with count == 31, go to DONE. stall_o = 1.
  - DONE: stall_o = 0. EX/MEM captures the low 32 bits of the product plus the mul's control and destination. Go to IDLE.
- While stall_o = 1, EX/MEM loads a bubble: all four control outputs 0; data and address outputs don't-care but driven to 0.

## Timing
- Reset values: all registered outputs 0, FSM IDLE, count 0, stall_o 0.
- Non-mul instruction: one-cycle latency. Inputs present in cycle N appear on EX/MEM outputs after edge N.
- mul: stall_o is high for 33 consecutive cycles (IDLE detect + 32 BUSY). The result lands on EX/MEM after the DONE-cycle edge, 34 cycles after the mul entered EX.
- stall_o is combinational from the IDLE decode plus FSM state. Upstream holds ID/EX stable while stall_o is high.
- Operands are sampled once, at IDLE detect. Later forwarding changes do not affect the product.
- Reset asserted mid-multiply aborts the operation: the FSM returns to IDLE, stall_o drops asynchronously, and outputs clear.
- A back-to-back mul following DONE starts a fresh IDLE detect in the next cycle.

## Configuration
- MUL_EN defined: funct 0x18 runs the sequential multiplier and the stall logic is active.
- MUL_EN undefined: funct 0x18 is treated as unknown (result 0, single cycle). The FSM and multiplier are not compiled, and stall_o is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - ALUOp encodings and funct constants.
  - The ALU-control enum.
  - The multiplier state enum.
  - A data-width constant of 32.
- Sub-module ex_mul_seq contains the 32-cycle shift-add multiplier and its FSM, instantiated only under MUL_EN. Forwarding, ALU and the EX/MEM register stay in ex_stage.

## Test plan
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately, stall_o 0.
- R-type add with RS=5, RT=7, no hazards -> next cycle ALUresult_o = 12, RDaddr_o = RDaddr_i, RegWrite_o = 1.
- Forwarding:
  - Back-to-back dependent add, prior result 12 to r3, next instruction uses r3 + r3 -> ALUresult_o = 24 (EX/MEM path).
  - With WB also writing r3 = 99 -> EX/MEM still wins.
  - Writes to r0 are never forwarded.
- slt signed: RS = 0xFFFFFFFF, RT = 1 -> 1. ALUOp 11 with imm 0x00F0 and RS = 0x0F -> 0xFF. Unknown funct 0x3F -> 0.
- MUL_EN, mul 0x10000 * 0x30003:
  - stall_o high for exactly 33 cycles.
  - Bubbles (controls 0) on EX/MEM throughout.
  - Then ALUresult_o = 0x00030000 with RegWrite_o = 1.
- MUL_EN, reset at BUSY count 10 -> FSM IDLE, stall_o 0; the next mul completes correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALUOp/funct encodings, ALU-control and multiplier-state enums.
package cpu_pkg;
    localparam int DW = 32;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL, ALU_NOP} alu_ctrl_e;
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic          mem_write;
        logic          mem_read;
        logic [DW-1:0] result;
        logic [DW-1:0] wdata;
        logic [4:0]    rd;
    } exmem_t;

    function automatic alu_ctrl_e alu_decode(input logic [1:0] op, input logic [5:0] funct);
        return op == ALUOP_ADD ? ALU_ADD :
               op == ALUOP_SUB ? ALU_SUB :
               op == ALUOP_OR  ? ALU_OR  :
               funct == FUNCT_ADD ? ALU_ADD :
               funct == FUNCT_SUB ? ALU_SUB :
               funct == FUNCT_AND ? ALU_AND :
               funct == FUNCT_OR  ? ALU_OR  :
               funct == FUNCT_SLT ? ALU_SLT :
               funct == FUNCT_MUL ? ALU_MUL : ALU_NOP;
    endfunction
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: 32-step shift-add multiplier (low 32 bits) with IDLE/BUSY/DONE control.
module ex_mul_seq import cpu_pkg::*; (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          stall_o,
    output logic [DW-1:0] product_o
);
    mul_state_e    state_q;
    logic [4:0]    cnt_q;
    logic [DW-1:0] a_q, b_q, acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: if (start_i) begin
                    a_q     <= a_i;
                    b_q     <= b_i;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= MUL_BUSY;
                end
                MUL_BUSY: begin
                    acc_q   <= b_q[0] ? acc_q + a_q : acc_q;
                    a_q     <= a_q << 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + 5'd1;
                    state_q <= cnt_q == 5'd31 ? MUL_DONE : MUL_BUSY;
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    // Gated by reset so an aborted multiply releases the pipeline immediately.
    assign stall_o   = !rst_i && ((state_q == MUL_IDLE && start_i) || state_q == MUL_BUSY);
    assign product_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU and EX/MEM register of the 5-stage CPU.
// Define MUL_EN to enable the stalling sequential multiplier (funct 0x18).
module ex_stage import cpu_pkg::*; (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          RegWrite_i,
    input  logic          MemtoReg_i,
    input  logic          MemWrite_i,
    input  logic          MemRead_i,
    input  logic          ALUSrc_i,
    input  logic          RegDst_i,
    input  logic [1:0]    ALUOp_i,
    input  logic [DW-1:0] RSdata_i,
    input  logic [DW-1:0] RTdata_i,
    input  logic [DW-1:0] Sign_extend_i,
    input  logic [4:0]    RSaddr_i,
    input  logic [4:0]    RTaddr_i,
    input  logic [4:0]    RDaddr_i,
    input  logic          WB_RegWrite_i,
    input  logic [4:0]    WB_RDaddr_i,
    input  logic [DW-1:0] WB_data_i,
    output logic          RegWrite_o,
    output logic          MemtoReg_o,
    output logic          MemWrite_o,
    output logic          MemRead_o,
    output logic [DW-1:0] ALUresult_o,
    output logic [DW-1:0] MemWdata_o,
    output logic [4:0]    RDaddr_o,
    output logic          stall_o
);
    exmem_t        exmem_d, exmem_q;
    alu_ctrl_e     ctrl;
    logic [DW-1:0] rs_fwd, rt_fwd, op_b, mul_res, alu_res;

    // EX/MEM beats WB; r0 is never forwarded.
    function automatic logic [DW-1:0] fwd(input logic [4:0] addr, input logic [DW-1:0] id_data,
                                          input exmem_t em, input logic wb_we,
                                          input logic [4:0] wb_rd, input logic [DW-1:0] wb_data);
        return (em.reg_write && em.rd != 5'd0 && em.rd == addr) ? em.result :
               (wb_we && wb_rd != 5'd0 && wb_rd == addr) ? wb_data : id_data;
    endfunction

    assign rs_fwd = fwd(RSaddr_i, RSdata_i, exmem_q, WB_RegWrite_i, WB_RDaddr_i, WB_data_i);
    assign rt_fwd = fwd(RTaddr_i, RTdata_i, exmem_q, WB_RegWrite_i, WB_RDaddr_i, WB_data_i);
    assign op_b   = ALUSrc_i ? Sign_extend_i : rt_fwd;
    assign ctrl   = alu_decode(ALUOp_i, Sign_extend_i[5:0]);

`ifdef MUL_EN
    ex_mul_seq u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (ctrl == ALU_MUL),
        .a_i       (rs_fwd),
        .b_i       (rt_fwd),
        .stall_o   (stall_o),
        .product_o (mul_res)
    );
`else
    assign stall_o = 1'b0;
    assign mul_res = '0;
`endif

    always_comb begin
        alu_res = ctrl == ALU_ADD ? rs_fwd + op_b :
                  ctrl == ALU_SUB ? rs_fwd - op_b :
                  ctrl == ALU_AND ? rs_fwd & op_b :
                  ctrl == ALU_OR  ? rs_fwd | op_b :
                  ctrl == ALU_SLT ? {{(DW-1){1'b0}}, $signed(rs_fwd) < $signed(op_b)} :
                  ctrl == ALU_MUL ? mul_res : '0;
        exmem_d = stall_o ? '0 : exmem_t'{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i,
                                          mem_write: MemWrite_i, mem_read: MemRead_i,
                                          result: alu_res, wdata: rt_fwd,
                                          rd: RegDst_i ? RDaddr_i : RTaddr_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) exmem_q <= '0;
        else       exmem_q <= exmem_d;
    end

    assign RegWrite_o  = exmem_q.reg_write;
    assign MemtoReg_o  = exmem_q.mem_to_reg;
    assign MemWrite_o  = exmem_q.mem_write;
    assign MemRead_o   = exmem_q.mem_read;
    assign ALUresult_o = exmem_q.result;
    assign MemWdata_o  = exmem_q.wdata;
    assign RDaddr_o    = exmem_q.rd;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage; multiplier steps run when MUL_EN is defined.
module tb_ex_stage;
    logic        clk_i = 1'b0, rst_i;
    logic        RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegDst_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RSdata_i, RTdata_i, Sign_extend_i, WB_data_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, WB_RDaddr_i;
    logic        WB_RegWrite_i;
    logic        RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o, stall_o;
    logic [31:0] ALUresult_o, MemWdata_o;
    logic [4:0]  RDaddr_o;

    typedef struct {
        string       tag;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i),
        .MemRead_i(MemRead_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Sign_extend_i(Sign_extend_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .WB_RegWrite_i(WB_RegWrite_i), .WB_RDaddr_i(WB_RDaddr_i), .WB_data_i(WB_data_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .ALUresult_o(ALUresult_o), .MemWdata_o(MemWdata_o),
        .RDaddr_o(RDaddr_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {28'b0, RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o}, 32'h0);
        check({tag, "_res"}, ALUresult_o, 32'h0);
        check({tag, "_wd"}, MemWdata_o, 32'h0);
        check({tag, "_rd"}, {27'b0, RDaddr_o}, 32'h0);
        check({tag, "_stall"}, {31'b0, stall_o}, 32'h0);
    endtask

    task automatic push(input string tag, input logic [3:0] ctl, input logic [31:0] res,
                        input logic [31:0] wd, input logic [4:0] rd);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.res = res; e.wd = wd; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_ctl"}, {28'b0, RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o}, {28'b0, e.ctl});
            check({e.tag, "_res"}, ALUresult_o, e.res);
            check({e.tag, "_wd"}, MemWdata_o, e.wd);
            check({e.tag, "_rd"}, {27'b0, RDaddr_o}, {27'b0, e.rd});
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        compare_next();
    endtask

    task automatic drive_r(input logic [5:0] funct, input logic [4:0] rsa, input logic [31:0] rs,
                           input logic [4:0] rta, input logic [31:0] rt, input logic [4:0] rda);
        RegWrite_i = 1; MemtoReg_i = 0; MemWrite_i = 0; MemRead_i = 0;
        ALUSrc_i = 0; RegDst_i = 1; ALUOp_i = 2'b10;
        Sign_extend_i = {26'b0, funct};
        RSaddr_i = rsa; RSdata_i = rs; RTaddr_i = rta; RTdata_i = rt; RDaddr_i = rda;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] prod);
        int n = 0;
        drive_r(6'h18, 5'd22, a, 5'd23, b, rd);
        push("mul_result", 4'b1000, prod, b, rd);
        #1;
        while (stall_o && n < 60) begin
            @(posedge clk_i);
            #1;
            n++;
            check("mul_bubble", {28'b0, RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o}, 32'h0);
        end
        check("mul_stall_cycles", n, 33);
        step();
    endtask

    initial begin
        rst_i = 1;
        {RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegDst_i} = '0;
        ALUOp_i = 0; RSdata_i = 0; RTdata_i = 0; Sign_extend_i = 0;
        RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0;
        WB_RegWrite_i = 0; WB_RDaddr_i = 0; WB_data_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset_state");
        rst_i = 0;

        drive_r(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        push("add", 4'b1000, 32'd12, 32'd7, 5'd3);
        step();

        drive_r(6'h20, 5'd3, 32'd0, 5'd3, 32'd0, 5'd4);
        WB_RegWrite_i = 1; WB_RDaddr_i = 5'd3; WB_data_i = 32'd99;
        push("fwd_exmem", 4'b1000, 32'd24, 32'd12, 5'd4);
        step();

        drive_r(6'h20, 5'd5, 32'd1, 5'd6, 32'd2, 5'd7);
        WB_RDaddr_i = 5'd5; WB_data_i = 32'd100;
        push("fwd_wb", 4'b1000, 32'd102, 32'd2, 5'd7);
        step();

        drive_r(6'h20, 5'd8, 32'd10, 5'd9, 32'd20, 5'd0);
        WB_RDaddr_i = 5'd0; WB_data_i = 32'd55;
        push("write_r0", 4'b1000, 32'd30, 32'd20, 5'd0);
        step();

        drive_r(6'h20, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10);
        push("no_fwd_r0", 4'b1000, 32'd0, 32'd0, 5'd10);
        step();
        WB_RegWrite_i = 0;

        drive_r(6'h2A, 5'd11, 32'hFFFF_FFFF, 5'd12, 32'd1, 5'd14);
        push("slt_signed", 4'b1000, 32'd1, 32'd1, 5'd14);
        step();

        drive_r(6'h00, 5'd15, 32'h0F, 5'd13, 32'h1234, 5'd0);
        ALUOp_i = 2'b11; ALUSrc_i = 1; RegDst_i = 0; Sign_extend_i = 32'h00F0;
        push("ori", 4'b1000, 32'hFF, 32'h1234, 5'd13);
        step();

        drive_r(6'h3F, 5'd1, 32'd3, 5'd2, 32'd4, 5'd16);
        push("unknown_funct", 4'b1000, 32'd0, 32'd4, 5'd16);
        step();

        drive_r(6'h22, 5'd1, 32'd10, 5'd2, 32'd3, 5'd17);
        push("sub", 4'b1000, 32'd7, 32'd3, 5'd17);
        step();

        drive_r(6'h24, 5'd1, 32'hF0F0, 5'd2, 32'hFF00, 5'd19);
        push("and", 4'b1000, 32'hF000, 32'hFF00, 5'd19);
        step();

        drive_r(6'h00, 5'd24, 32'h100, 5'd18, 32'hABCD, 5'd0);
        ALUOp_i = 2'b00; ALUSrc_i = 1; RegDst_i = 0; MemRead_i = 1; MemtoReg_i = 1;
        Sign_extend_i = 32'd8;
        push("load", 4'b1101, 32'h108, 32'hABCD, 5'd18);
        step();

        drive_r(6'h00, 5'd25, 32'h200, 5'd20, 32'h55, 5'd0);
        ALUOp_i = 2'b01; ALUSrc_i = 1; RegDst_i = 0; RegWrite_i = 0; MemWrite_i = 1;
        Sign_extend_i = 32'd4;
        push("store_sub", 4'b0010, 32'h1FC, 32'h55, 5'd20);
        step();

`ifdef MUL_EN
        run_mul(32'h0001_0000, 32'h0003_0003, 5'd26, 32'h0003_0000);
        drive_r(6'h18, 5'd22, 32'd7, 5'd23, 32'd6, 5'd21);
        repeat (11) @(posedge clk_i);
        #1;
        rst_i = 1;
        #1;
        check("abort_stall", {31'b0, stall_o}, 32'h0);
        check("abort_regwrite", {31'b0, RegWrite_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        run_mul(32'd7, 32'd6, 5'd21, 32'd42);
`else
        drive_r(6'h18, 5'd1, 32'd6, 5'd2, 32'd7, 5'd21);
        #1;
        check("mul_disabled_stall", {31'b0, stall_o}, 32'h0);
        push("mul_disabled", 4'b1000, 32'd0, 32'd7, 5'd21);
        step();
`endif

        #3;
        rst_i = 1;
        #1;
        check_zero("async_reset");
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
